// File: rtl/riscv_ctrl_pkg.sv
// Shared types and constants for the multicycle instruction controller.
package riscv_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DECODE,
        ST_EXEC,
        ST_WB,
        ST_TRAP
    } state_t;

    localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
    localparam logic [6:0] OPC_IALU   = 7'b0010011;

    localparam logic [6:0] F7_BASE    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;

    localparam int unsigned ALU_CTRL_W = 4;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational decode of latched instruction fields into legality and ALU controls.
module ctrl_decode
    import riscv_ctrl_pkg::*;
(
    input  logic [6:0]            opcode,
    input  logic [2:0]            funct3,
    input  logic [6:0]            funct7,
    output logic                  legal,
    output logic                  alu_src_imm,
    output logic [ALU_CTRL_W-1:0] alu_ctrl
);

    always_comb begin
        legal       = 1'b0;
        alu_src_imm = 1'b0;
        alu_ctrl    = {1'b0, funct3};
        case (opcode)
            OPC_RTYPE: begin
                alu_ctrl[3] = funct7[5];
                legal = (funct7 == F7_BASE) ||
                        ((funct7 == F7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
            end
            OPC_IALU: begin
                alu_src_imm = 1'b1;
                // funct7 is immediate data except for the shift-immediate encodings
                alu_ctrl[3] = (funct3 == 3'b101) && funct7[5];
                case (funct3)
                    3'b001:  legal = (funct7 == F7_BASE);
                    3'b101:  legal = (funct7 == F7_BASE) || (funct7 == F7_ALT);
                    default: legal = 1'b1;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle IDLE/DECODE/EXEC/WB/TRAP controller for ALU-type instructions.
// Optional macro RETIRE_CNT_EN adds a 32-bit retired-instruction counter output.
module multicycle_ctrl
    import riscv_ctrl_pkg::*;
#(
    parameter int unsigned EXEC_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  instr_valid,
    output logic                  instr_ready,
    input  logic [6:0]            opcode,
    input  logic [2:0]            funct3,
    input  logic [6:0]            funct7,
    input  logic [4:0]            rd,
    output logic                  reg_wr,
    output logic                  alu_src_imm,
    output logic [ALU_CTRL_W-1:0] alu_ctrl,
    output logic [4:0]            wr_addr,
    output logic                  retire,
    output logic                  illegal
`ifdef RETIRE_CNT_EN
    ,
    output logic [31:0]           retire_cnt
`endif
);

    state_t                state_q, state_d;
    logic [3:0]            cnt_q;
    logic [6:0]            opcode_q;
    logic [2:0]            funct3_q;
    logic [6:0]            funct7_q;
    logic [4:0]            rd_q;
    logic                  live_q;
    logic                  accept;
    logic                  dec_legal;
    logic                  dec_imm;
    logic [ALU_CTRL_W-1:0] dec_ctrl;

    ctrl_decode u_decode (
        .opcode      (opcode_q),
        .funct3      (funct3_q),
        .funct7      (funct7_q),
        .legal       (dec_legal),
        .alu_src_imm (dec_imm),
        .alu_ctrl    (dec_ctrl)
    );

    assign accept = instr_valid && instr_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Holds instr_ready low for the first cycle after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) live_q <= 1'b0;
        else        live_q <= 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opcode_q <= '0;
            funct3_q <= '0;
            funct7_q <= '0;
            rd_q     <= '0;
        end else if (accept) begin
            opcode_q <= opcode;
            funct3_q <= funct3;
            funct7_q <= funct7;
            rd_q     <= rd;
        end
    end

    // Loaded in DECODE so EXEC sees EXEC_CYCLES-1 .. 0, leaving on zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                    cnt_q <= '0;
        else if (state_q == ST_DECODE)                 cnt_q <= 4'(EXEC_CYCLES - 1);
        else if ((state_q == ST_EXEC) && (cnt_q != '0)) cnt_q <= cnt_q - 4'd1;
    end

    always_comb begin
        state_d     = state_q;
        instr_ready = 1'b0;
        reg_wr      = 1'b0;
        retire      = 1'b0;
        illegal     = 1'b0;
        alu_src_imm = 1'b0;
        alu_ctrl    = '0;
        wr_addr     = rd_q;
        case (state_q)
            ST_IDLE: begin
                instr_ready = live_q;
                if (instr_valid && live_q) state_d = ST_DECODE;
            end
            ST_DECODE: begin
                alu_src_imm = dec_imm;
                alu_ctrl    = dec_ctrl;
                state_d     = dec_legal ? ST_EXEC : ST_TRAP;
            end
            ST_EXEC: begin
                alu_src_imm = dec_imm;
                alu_ctrl    = dec_ctrl;
                if (cnt_q == '0) state_d = ST_WB;
            end
            ST_WB: begin
                alu_src_imm = dec_imm;
                alu_ctrl    = dec_ctrl;
                reg_wr      = (rd_q != '0);
                retire      = 1'b1;
                state_d     = ST_IDLE;
            end
            ST_TRAP: begin
                illegal = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

`ifdef RETIRE_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)               retire_cnt <= '0;
        else if (state_q == ST_WB) retire_cnt <= retire_cnt + 32'd1;
    end
`endif

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter EXEC_CYCLES, default 1, number of EXEC-state cycles (1..15) allowed for ALU/regbank settling.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 instr_valid  input  1  decoded instruction fields are valid.
REQ-005 instr_ready  output  1  controller can accept an instruction.
REQ-006 opcode  input  7  instruction opcode field.
REQ-007 funct3 / funct7  input  3 / 7  instruction function fields.
REQ-008 rd  input  5  destination register index.
REQ-009 reg_wr  output  1  register-bank write enable.
REQ-010 alu_src_imm  output  1  0 selects rs2 data, 1 selects sign-extended immediate.
REQ-011 alu_ctrl  output  4  {sub_sra, funct3} operation select for the ALU.
REQ-012 wr_addr  output  5  latched rd driven to the register bank.
REQ-013 retire  output  1  one-cycle pulse when an instruction completes.
REQ-014 illegal  output  1  one-cycle pulse on an unsupported instruction.

Function
REQ-015 FSM states SHALL be IDLE, DECODE, EXEC, WB, TRAP.
REQ-016 instr_ready SHALL be 1 only in IDLE; accept = instr_valid && instr_ready.
REQ-017 On accept, opcode, funct3, funct7 and rd SHALL be latched, and the FSM SHALL go to DECODE; inputs are ignored until the next IDLE.
REQ-018 DECODE, 1 cycle: legal goes to EXEC, illegal goes to TRAP.
REQ-019 Legal means R-type (0110011) with funct7 of 0000000 or 0100000, or I-ALU (0010011); funct7 of 0100000 is legal only with funct3 of 000 or 101, and I-ALU funct3=001/101 requires funct7 of 0000000 or 0100000 (the latter only with 101).
REQ-020 alu_src_imm SHALL be 1 for I-ALU and 0 for R-type, held from DECODE through WB.
REQ-021 alu_ctrl[3] SHALL be funct7[5] for R-type, and funct7[5] for I-ALU only when funct3=101, else 0; alu_ctrl[2:0] = funct3.
REQ-022 EXEC SHALL last exactly EXEC_CYCLES cycles, counted by an internal down-counter, then go to WB.
REQ-023 WB, 1 cycle: reg_wr=1 unless latched rd=0 (x0 write suppressed); retire=1; next state IDLE.
REQ-024 TRAP, 1 cycle: illegal=1, reg_wr=0, retire=0; next state IDLE.
REQ-025 reg_wr SHALL never be asserted outside WB.
REQ-026 Accept-to-retire latency = EXEC_CYCLES+2 cycles; throughput is one instruction per EXEC_CYCLES+3 cycles.
REQ-027 instr_valid held high across IDLE SHALL be accepted on the first IDLE cycle, with no bubble beyond the FSM sequence.

Reset
REQ-028 While rst_n=0: state IDLE; counter 0; latched fields 0; reg_wr, alu_src_imm, alu_ctrl, wr_addr, retire, illegal all 0; instr_ready 0.
REQ-029 Reset asserted mid-instruction SHALL abort without reg_wr; instr_ready rises 1 cycle after rst_n deasserts.

Configuration
REQ-030 Macro RETIRE_CNT_EN: when defined, add output retire_cnt (32 bits), reset to 0, incremented on each retire, wrapping from FFFFFFFF to 0; when undefined, the port and the counter are absent and behaviour is otherwise identical.

Structure
REQ-031 Package riscv_ctrl_pkg SHALL hold the state enum, the OPC_RTYPE/OPC_IALU constants and the ALU_CTRL width.
REQ-032 Combinational sub-module ctrl_decode SHALL map latched fields to legal, alu_src_imm and alu_ctrl.

Verification
REQ-033 add x6,x28,x6 (0000000_00110_11100_000_00110_0110011), EXEC_CYCLES=1 -> reg_wr=1, wr_addr=6, alu_src_imm=0, alu_ctrl=0000 at accept+3; retire same cycle.
REQ-034 addi x6,x28,3 (opcode 0010011) -> alu_src_imm=1, reg_wr at accept+3.
REQ-035 sub (funct7=0100000, funct3=000) -> alu_ctrl=1000; rd=0 variant -> retire=1, reg_wr=0.
REQ-036 opcode 0000011 -> illegal pulse at accept+2, no reg_wr, instr_ready back at accept+3.
REQ-037 EXEC_CYCLES=4 with back-to-back instr_valid -> accepts every 7 cycles; rst_n=0 during EXEC -> no reg_wr, all outputs 0.
